cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 131 +++++++++++++
 tb/tb_cdb_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Three-way round-robin arbiter for the common data bus; one result
//            per cycle is broadcast one cycle after its grant.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Flush,
    input  logic              Add_req,
    input  logic              Mul_req,
    input  logic              Mem_req,
    input  logic [TAG_W-1:0]  Add_tag,
    input  logic [TAG_W-1:0]  Mul_tag,
    input  logic [TAG_W-1:0]  Mem_tag,
    input  logic [DATA_W-1:0] Add_data,
    input  logic [DATA_W-1:0] Mul_data,
    input  logic [DATA_W-1:0] Mem_data,
    output logic              Add_gnt,
    output logic              Mul_gnt,
    output logic              Mem_gnt,
    output logic              CDB_valid,
    output logic [TAG_W-1:0]  CDB_tag,
    output logic [DATA_W-1:0] CDB_data,
    output logic              Conflict
);

    localparam logic [1:0] c_ADD = 2'd0;
    localparam logic [1:0] c_MUL = 2'd1;
    localparam logic [1:0] c_MEM = 2'd2;

    logic [1:0]        r_ptr;
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;

    logic              w_add_v;
    logic              w_mul_v;
    logic              w_mem_v;
    logic [1:0]        w_ptr;
    logic [2:0]        w_pick;   // {mem, mul, add}, before reset/flush gating
    logic [2:0]        w_gnt;
    logic [1:0]        w_ptr_next;
    logic [TAG_W-1:0]  w_sel_tag;
    logic [DATA_W-1:0] w_sel_data;

    // Tag 0 marks "no producer", so such a request is ignored entirely.
    assign w_add_v = Add_req && (Add_tag != '0);
    assign w_mul_v = Mul_req && (Mul_tag != '0);
    assign w_mem_v = Mem_req && (Mem_tag != '0);

    assign w_ptr    = (r_ptr == 2'd3) ? c_ADD : r_ptr;
    assign Conflict = (w_add_v && w_mul_v) || (w_add_v && w_mem_v) || (w_mul_v && w_mem_v);

    always_comb begin
        w_pick = 3'b000;
        case (w_ptr)
            c_MUL: begin
                if (w_mul_v)      w_pick = 3'b010;
                else if (w_mem_v) w_pick = 3'b100;
                else if (w_add_v) w_pick = 3'b001;
            end
            c_MEM: begin
                if (w_mem_v)      w_pick = 3'b100;
                else if (w_add_v) w_pick = 3'b001;
                else if (w_mul_v) w_pick = 3'b010;
            end
            default: begin
                if (w_add_v)      w_pick = 3'b001;
                else if (w_mul_v) w_pick = 3'b010;
                else if (w_mem_v) w_pick = 3'b100;
            end
        endcase
    end

    assign w_gnt   = (RST || Flush) ? 3'b000 : w_pick;
    assign Add_gnt = w_gnt[0];
    assign Mul_gnt = w_gnt[1];
    assign Mem_gnt = w_gnt[2];

    always_comb begin
        w_ptr_next = w_ptr;
        w_sel_tag  = Add_tag;
        w_sel_data = Add_data;
        case (w_gnt)
            3'b001: w_ptr_next = c_MUL;
            3'b010: begin
                w_ptr_next = c_MEM;
                w_sel_tag  = Mul_tag;
                w_sel_data = Mul_data;
            end
            3'b100: begin
                w_ptr_next = c_ADD;
                w_sel_tag  = Mem_tag;
                w_sel_data = Mem_data;
            end
            default: ;
        endcase
    end

    // Flush leaves the last tag/data in place; only reset clears them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr       <= c_ADD;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else if (Flush) begin
            r_ptr       <= c_ADD;
            r_cdb_valid <= 1'b0;
        end else if (w_gnt != 3'b000) begin
            r_ptr       <= w_ptr_next;
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= w_sel_tag;
            r_cdb_data  <= w_sel_data;
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign CDB_valid = r_cdb_valid;
    assign CDB_tag   = r_cdb_tag;
    assign CDB_data  = r_cdb_data;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed vector bench for cdb_arbiter; each record is one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;

    logic              CLK = 1'b0;
    logic              RST, Flush;
    logic              Add_req, Mul_req, Mem_req;
    logic [TAG_W-1:0]  Add_tag, Mul_tag, Mem_tag;
    logic [DATA_W-1:0] Add_data, Mul_data, Mem_data;
    logic              Add_gnt, Mul_gnt, Mem_gnt;
    logic              CDB_valid;
    logic [TAG_W-1:0]  CDB_tag;
    logic [DATA_W-1:0] CDB_data;
    logic              Conflict;

    int n_checks = 0;
    int n_errors = 0;

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .RST(RST), .Flush(Flush),
        .Add_req(Add_req), .Mul_req(Mul_req), .Mem_req(Mem_req),
        .Add_tag(Add_tag), .Mul_tag(Mul_tag), .Mem_tag(Mem_tag),
        .Add_data(Add_data), .Mul_data(Mul_data), .Mem_data(Mem_data),
        .Add_gnt(Add_gnt), .Mul_gnt(Mul_gnt), .Mem_gnt(Mem_gnt),
        .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
        .Conflict(Conflict)
    );

    always #5 CLK = ~CLK;

    // Inputs applied in a cycle, comb outputs expected in that cycle, and the
    // registered CDB state expected to be visible in that same cycle.
    typedef struct {
        logic              rst;
        logic              flush;
        logic [2:0]        req;   // {mem, mul, add}
        logic [TAG_W-1:0]  at, mt, et;
        logic [2:0]        gnt;   // {mem, mul, add}
        logic              conf;
        logic              v;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic flush, input logic [2:0] req,
                                input int at, input int mt, input int et,
                                input logic [2:0] gnt, input logic conf,
                                input logic v, input int tag, input logic [31:0] data);
        vec_t r;
        r.rst = rst; r.flush = flush; r.req = req;
        r.at = TAG_W'(at); r.mt = TAG_W'(mt); r.et = TAG_W'(et);
        r.gnt = gnt; r.conf = conf; r.v = v; r.tag = TAG_W'(tag); r.data = data;
        return r;
    endfunction

    // Result payloads are derived from the tag so each source is distinguishable.
    task automatic drive(input logic rst, input logic flush, input logic [2:0] req,
                         input logic [TAG_W-1:0] at, input logic [TAG_W-1:0] mt,
                         input logic [TAG_W-1:0] et);
        RST = rst; Flush = flush;
        Add_req = req[0]; Mul_req = req[1]; Mem_req = req[2];
        Add_tag = at; Mul_tag = mt; Mem_tag = et;
        Add_data = 32'h1231 + 32'(at);
        Mul_data = 32'h2000 + 32'(mt);
        Mem_data = 32'h3000 + 32'(et);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    initial begin
        //               rst flush req    at mt et  gnt    conf v tag data
        vecs.push_back(mk(1, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0));     // 0 reset state
        vecs.push_back(mk(0, 0, 3'b001, 3, 0, 0, 3'b001, 0, 0, 0, 32'h0));     // 1 single ADD
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 1, 3, 32'h1234));  // 2 broadcast
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 3, 32'h1234));  // 3 valid drops
        vecs.push_back(mk(1, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 3, 32'h1234));  // 4 re-reset
        vecs.push_back(mk(0, 0, 3'b111, 1, 4, 7, 3'b001, 1, 0, 0, 32'h0));     // 5 3-way: ADD
        vecs.push_back(mk(0, 0, 3'b111, 1, 4, 7, 3'b010, 1, 1, 1, 32'h1232));  // 6 MUL
        vecs.push_back(mk(0, 0, 3'b111, 1, 4, 7, 3'b100, 1, 1, 4, 32'h2004));  // 7 MEM
        vecs.push_back(mk(0, 0, 3'b111, 1, 4, 7, 3'b001, 1, 1, 7, 32'h3007));  // 8 ADD
        vecs.push_back(mk(0, 0, 3'b111, 1, 4, 7, 3'b010, 1, 1, 1, 32'h1232));  // 9 MUL
        vecs.push_back(mk(0, 0, 3'b111, 1, 4, 7, 3'b100, 1, 1, 4, 32'h2004));  // 10 MEM
        vecs.push_back(mk(0, 0, 3'b101, 1, 0, 7, 3'b001, 1, 1, 7, 32'h3007));  // 11 wrap: ADD
        vecs.push_back(mk(0, 0, 3'b101, 1, 0, 7, 3'b100, 1, 1, 1, 32'h1232));  // 12 then MEM
        vecs.push_back(mk(0, 0, 3'b010, 0, 0, 0, 3'b000, 0, 1, 7, 32'h3007));  // 13 tag-0 MUL
        vecs.push_back(mk(0, 0, 3'b010, 0, 0, 0, 3'b000, 0, 0, 7, 32'h3007));  // 14 still idle
        vecs.push_back(mk(0, 0, 3'b011, 2, 0, 0, 3'b001, 0, 0, 7, 32'h3007));  // 15 tag-0 no conflict
        vecs.push_back(mk(0, 1, 3'b011, 2, 4, 0, 3'b000, 1, 1, 2, 32'h1233));  // 16 flush, ptr=MUL
        vecs.push_back(mk(0, 0, 3'b011, 2, 4, 0, 3'b001, 1, 0, 2, 32'h1233));  // 17 ADD first
        vecs.push_back(mk(0, 0, 3'b010, 0, 4, 0, 3'b010, 0, 1, 2, 32'h1233));  // 18 MUL
        vecs.push_back(mk(0, 0, 3'b010, 0, 5, 0, 3'b010, 0, 1, 4, 32'h2004));  // 19 back-to-back
        vecs.push_back(mk(0, 0, 3'b010, 0, 6, 0, 3'b010, 0, 1, 5, 32'h2005));  // 20 back-to-back
        vecs.push_back(mk(0, 0, 3'b100, 0, 0, 9, 3'b100, 0, 1, 6, 32'h2006));  // 21 MEM tag 9
        vecs.push_back(mk(1, 1, 3'b100, 0, 0, 9, 3'b000, 0, 1, 9, 32'h3009));  // 22 RST beats Flush
        vecs.push_back(mk(0, 0, 3'b101, 1, 0, 9, 3'b001, 1, 0, 0, 32'h0));     // 23 ADD first
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 1, 1, 32'h1232));  // 24 broadcast

        drive(1, 0, 3'b000, '0, '0, '0);
        repeat (2) @(posedge CLK);

        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            drive(vecs[i].rst, vecs[i].flush, vecs[i].req, vecs[i].at, vecs[i].mt, vecs[i].et);
            @(negedge CLK);
            check("gnt",       i, {29'd0, Mem_gnt, Mul_gnt, Add_gnt}, {29'd0, vecs[i].gnt});
            check("conflict",  i, {31'd0, Conflict},  {31'd0, vecs[i].conf});
            check("cdb_valid", i, {31'd0, CDB_valid}, {31'd0, vecs[i].v});
            check("cdb_tag",   i, {27'd0, CDB_tag},   {27'd0, vecs[i].tag});
            check("cdb_data",  i, CDB_data, vecs[i].data);
            @(posedge CLK);
        end

        // Fairness: pointer now at MUL after vector 23; MEM must win within 3 cycles.
        begin
            int waited;
            logic seen;
            waited = 0;
            seen   = 1'b0;
            while (!seen && waited < 3) begin
                #1;
                drive(0, 0, 3'b111, 5'd1, 5'd4, 5'd7);
                @(negedge CLK);
                waited++;
                if (Mem_gnt) seen = 1'b1;
                @(posedge CLK);
            end
            check("mem_fair_seen", 0, {31'd0, seen}, 32'd1);
            check("mem_fair_cycles", 0, 32'(waited), 32'd2);
            @(negedge CLK);
            check("mem_fair_tag", 0, {27'd0, CDB_tag}, 32'd7);
            check("mem_fair_data", 0, CDB_data, 32'h3007);
        end

        drive(0, 0, 3'b000, '0, '0, '0);
        @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
